// File: rtl/matrix_window_streamer.sv
// Fetches a run of LANES-wide rows from parallel RAM lanes and streams OUT_NUM-wide sliding windows
// over valid/ready. Define MATRIX_WINDOW_ZERO_PAD_EN to also emit zero-padded windows past the row edge.
module matrix_window_streamer #(
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 8,
  parameter int LANES       = 8,
  parameter int OUT_NUM     = 3,
  parameter int STRIDE      = 1,
  parameter int RAM_LATENCY = 2,
  parameter int ADDR_WIDTH  = $clog2(MEM_DEPTH)
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [ADDR_WIDTH:0]           row_count,
  output logic [LANES*ADDR_WIDTH-1:0]   addr_row_o,
  input  logic [LANES*DATA_WIDTH-1:0]   mem_row_i,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic [OUT_NUM*DATA_WIDTH-1:0] mem_row_o,
  output logic [$clog2(LANES):0]        win_idx,
  output logic                          last,
  output logic                          busy,
  output logic                          done
);

  localparam int FIFO_DEPTH = RAM_LATENCY + 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(2 * FIFO_DEPTH + 1);
  localparam int POS_W      = $clog2(LANES) + 1;
`ifdef MATRIX_WINDOW_ZERO_PAD_EN
  localparam int NUM_WIN    = (LANES + STRIDE - 1) / STRIDE;
`else
  localparam int NUM_WIN    = (LANES - OUT_NUM) / STRIDE + 1;
`endif
  localparam int LAST_POS   = (NUM_WIN - 1) * STRIDE;

  localparam logic [POS_W-1:0]      POS_STEP = POS_W'(STRIDE);
  localparam logic [POS_W-1:0]      POS_LAST = POS_W'(LAST_POS);
  localparam logic [ADDR_WIDTH:0]   ROW_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [PTR_W-1:0]      PTR_MAX  = PTR_W'(FIFO_DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_MAX) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  logic [1:0]                    r_state;
  logic                          r_busy;
  logic                          r_done;
  logic [ADDR_WIDTH:0]           r_rows;
  logic [ADDR_WIDTH:0]           r_issued;
  logic [ADDR_WIDTH-1:0]         r_addr;
  logic                          r_issue;
  logic [RAM_LATENCY-1:0]        r_vld_sr;
  logic [LANES*DATA_WIDTH-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]              r_wr_ptr;
  logic [PTR_W-1:0]              r_rd_ptr;
  logic [CNT_W-1:0]              r_cnt;
  logic [POS_W-1:0]              r_pos;
  logic [ADDR_WIDTH:0]           r_popped;
  logic                          r_data_valid;
  logic [OUT_NUM*DATA_WIDTH-1:0] r_mem_row_o;
  logic [POS_W-1:0]              r_win_idx;
  logic                          r_last;

  logic                          w_push;
  logic                          w_hs;
  logic                          w_pop;
  logic [CNT_W-1:0]              w_inflight;
  logic                          w_sr_busy;
  logic [CNT_W-1:0]              w_cnt_nxt;
  logic                          w_credit;
  logic                          w_start_acc;
  logic                          w_issue;
  logic [PTR_W-1:0]              w_rd_ptr_nxt;
  logic [POS_W-1:0]              w_pos_nxt;
  logic [ADDR_WIDTH:0]           w_popped_nxt;
  logic [LANES*DATA_WIDTH-1:0]   w_head_nxt;
  logic                          w_valid_nxt;
  logic                          w_last_nxt;
  logic                          w_drain_done;
  logic [OUT_NUM*DATA_WIDTH-1:0] w_win_nxt;

  // Outstanding reads: the address on the bus plus every stage of the latency tracker.
  always_comb begin
    w_inflight = CNT_W'(r_issue);
    w_sr_busy  = r_issue;
    for (int i = 0; i < RAM_LATENCY; i++) begin
      w_inflight = w_inflight + CNT_W'(r_vld_sr[i]);
      w_sr_busy  = w_sr_busy | (r_vld_sr[i] & (i < RAM_LATENCY - 1));
    end
  end

  assign w_push       = r_vld_sr[RAM_LATENCY-1];
  assign w_hs         = r_data_valid & data_ready;
  assign w_pop        = w_hs & (r_pos == POS_LAST);
  assign w_cnt_nxt    = r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_credit     = (w_inflight + r_cnt) < CNT_W'(FIFO_DEPTH);
  assign w_start_acc  = (r_state == S_IDLE) & ~r_busy & start;
  assign w_issue      = (w_start_acc & (row_count != '0)) | ((r_state == S_FETCH) & w_credit);
  assign w_rd_ptr_nxt = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
  assign w_pos_nxt    = w_pop ? '0 : (w_hs ? r_pos + POS_STEP : r_pos);
  assign w_popped_nxt = w_pop ? r_popped + ROW_ONE : r_popped;
  // A row landing in an empty (or just-emptied) FIFO becomes the head immediately.
  assign w_head_nxt   = (w_push && (w_rd_ptr_nxt == r_wr_ptr)) ? mem_row_i : r_fifo[w_rd_ptr_nxt];
  assign w_valid_nxt  = (w_cnt_nxt != '0);
  assign w_last_nxt   = w_valid_nxt & (w_pos_nxt == POS_LAST) & (w_popped_nxt == r_rows - ROW_ONE);
  assign w_drain_done = (r_state == S_DRAIN) & (w_cnt_nxt == '0) & ~w_sr_busy;

  // Window selection from the next head row; lanes past the row edge read as zero.
  always_comb begin
    w_win_nxt = '0;
    for (int j = 0; j < OUT_NUM; j++) begin
      if (int'(w_pos_nxt) + j < LANES) begin
        w_win_nxt[j*DATA_WIDTH +: DATA_WIDTH] = w_head_nxt[(int'(w_pos_nxt) + j)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        w_win_nxt[j*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  // Control FSM; busy stays high through the done cycle so a coincident start is ignored.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rows   <= '0;
      r_issued <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (r_busy) begin
            r_busy <= 1'b0;
          end else if (start) begin
            r_busy   <= 1'b1;
            r_rows   <= row_count;
            r_issued <= (row_count != '0) ? ROW_ONE : '0;
            r_state  <= (row_count > ROW_ONE) ? S_FETCH : S_DRAIN;
          end
        end
        S_FETCH: begin
          if (w_credit) begin
            r_issued <= r_issued + ROW_ONE;
            if (r_issued + ROW_ONE == r_rows) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_drain_done) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Address issue with wrap past the last RAM entry, plus the read-latency tracker.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_addr   <= '0;
      r_issue  <= 1'b0;
      r_vld_sr <= '0;
    end else begin
      if (w_issue) begin
        r_addr <= w_start_acc ? base_addr : addr_inc(r_addr);
      end
      r_issue     <= w_issue;
      r_vld_sr[0] <= r_issue;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        r_vld_sr[i] <= r_vld_sr[i-1];
      end
    end
  end

  // Row FIFO and window position within the head row.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_pos    <= '0;
      r_popped <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= mem_row_i;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pos    <= w_pos_nxt;
      r_popped <= w_start_acc ? '0 : w_popped_nxt;
    end
  end

  // Output registers load the next-cycle view, so they hold while stalled.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_data_valid <= 1'b0;
      r_mem_row_o  <= '0;
      r_win_idx    <= '0;
      r_last       <= 1'b0;
    end else begin
      r_data_valid <= w_valid_nxt;
      r_mem_row_o  <= w_valid_nxt ? w_win_nxt : '0;
      r_win_idx    <= w_valid_nxt ? w_pos_nxt : '0;
      r_last       <= w_last_nxt;
    end
  end

  assign addr_row_o = {LANES{r_addr}};
  assign data_valid = r_data_valid;
  assign mem_row_o  = r_mem_row_o;
  assign win_idx    = r_win_idx;
  assign last       = r_last;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
